// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC, next-PC select,
// imem handshake, one-entry stall buffer and IF/ID register.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_rdata_i,
   input  logic        imem_valid_i,
   output logic [31:0] if_id_pc_o,
   output logic [31:0] if_id_pc4_o,
   output logic [31:0] if_id_inst_o,
   output logic        if_id_valid_o
);

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HOLD = 2'd1,
      KILL = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ibuf_q, ibuf_d;
   logic [31:0] tgt_q, tgt_d;
   logic [31:0] pc4;
   logic [31:0] rpc;
   logic        sel_mem, sel_buf, sel_bub;

   assign pc4 = pc_q + 32'd4;
   assign rpc = {redirect_pc_i[31:2], 2'b00};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= RUN;
      else        state_q <= state_d;
   end

   // Next state, next PC/target/buffer and IF/ID source select
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      tgt_d   = tgt_q;
      ibuf_d  = ibuf_q;
      sel_mem = 1'b0;
      sel_buf = 1'b0;
      sel_bub = 1'b0;
      unique case (state_q)
         RUN: begin
            if (redirect_i) begin
               sel_bub = 1'b1;
               if (imem_valid_i) begin
                  pc_d = rpc;
               end else begin
                  tgt_d   = rpc;
                  state_d = KILL;
               end
            end else if (imem_valid_i && !stall_i) begin
               sel_mem = 1'b1;
               pc_d    = pc4;
            end else if (imem_valid_i) begin
               ibuf_d  = imem_rdata_i;
               state_d = HOLD;
            end else if (!stall_i) begin
               sel_bub = 1'b1;
            end
         end
         HOLD: begin
            if (redirect_i) begin
               sel_bub = 1'b1;
               pc_d    = rpc;
               state_d = RUN;
            end else if (!stall_i) begin
               sel_buf = 1'b1;
               pc_d    = pc4;
               state_d = RUN;
            end
         end
         KILL: begin
            if (redirect_i) tgt_d = rpc;
            if (imem_valid_i) begin
               pc_d    = redirect_i ? rpc : tgt_q;
               state_d = RUN;
            end
            if (redirect_i || !stall_i) sel_bub = 1'b1;
         end
         default: state_d = RUN;
      endcase
   end

   // Memory request: no request while an instruction is parked
   always_comb begin
      imem_req_o  = rst_n && (state_q != HOLD);
      imem_addr_o = pc_q;
   end

   // PC, buffer, redirect target and IF/ID register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC;
         ibuf_q        <= '0;
         tgt_q         <= '0;
         if_id_pc_o    <= '0;
         if_id_pc4_o   <= '0;
         if_id_inst_o  <= NOP_INST;
         if_id_valid_o <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         ibuf_q <= ibuf_d;
         tgt_q  <= tgt_d;
         unique case (1'b1)
            sel_bub: begin
               if_id_pc_o    <= '0;
               if_id_pc4_o   <= '0;
               if_id_inst_o  <= NOP_INST;
               if_id_valid_o <= 1'b0;
            end
            sel_mem: begin
               if_id_pc_o    <= pc_q;
               if_id_pc4_o   <= pc4;
               if_id_inst_o  <= imem_rdata_i;
               if_id_valid_o <= 1'b1;
            end
            sel_buf: begin
               if_id_pc_o    <= pc_q;
               if_id_pc4_o   <= pc4;
               if_id_inst_o  <= ibuf_q;
               if_id_valid_o <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage with an in-bench
// behavioural model and variable-latency memory.
module tb_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_rdata_i;
   logic        imem_valid_i;
   logic [31:0] if_id_pc_o;
   logic [31:0] if_id_pc4_o;
   logic [31:0] if_id_inst_o;
   logic        if_id_valid_o;

   fetch_stage #(
      .RESET_PC(RST_PC),
      .NOP_INST(NOP)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .stall_i(stall_i),
      .redirect_i(redirect_i),
      .redirect_pc_i(redirect_pc_i),
      .imem_req_o(imem_req_o),
      .imem_addr_o(imem_addr_o),
      .imem_rdata_i(imem_rdata_i),
      .imem_valid_i(imem_valid_i),
      .if_id_pc_o(if_id_pc_o),
      .if_id_pc4_o(if_id_pc4_o),
      .if_id_inst_o(if_id_inst_o),
      .if_id_valid_o(if_id_valid_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   bit started = 0;

   // model: fetch pointer, IF/ID contents, parked word, pending kill
   logic [31:0] m_pc, m_ipc, m_ipc4, m_inst, m_tgt, m_buf;
   logic        m_ival, m_have_buf, m_kill;

   // memory model
   int          mwait = 0;
   bit          mbusy = 0;
   int          lat_max = 0;
   int          force_lat = -1;
   logic [31:0] key = 32'h0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_pc = RST_PC; m_ipc = 0; m_ipc4 = 0; m_inst = NOP;
      m_ival = 0; m_have_buf = 0; m_kill = 0; m_tgt = 0; m_buf = 0;
   endfunction

   function automatic void bubble();
      m_ipc = 0; m_ipc4 = 0; m_inst = NOP; m_ival = 0;
   endfunction

   function automatic void deliver(input logic [31:0] w);
      m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_inst = w; m_ival = 1;
      m_pc = m_pc + 32'd4;
   endfunction

   function automatic void model_step(input bit s, input bit r,
                                      input logic [31:0] rp_raw,
                                      input bit v, input logic [31:0] d);
      logic [31:0] rp;
      rp = rp_raw & 32'hFFFF_FFFC;
      if (m_kill) begin
         if (r) m_tgt = rp;
         if (v) begin
            m_pc = m_tgt;
            m_kill = 0;
         end
         if (r || !s) bubble();
      end else if (m_have_buf) begin
         if (r) begin
            bubble();
            m_pc = rp;
            m_have_buf = 0;
         end else if (!s) begin
            deliver(m_buf);
            m_have_buf = 0;
         end
      end else begin
         if (r) begin
            bubble();
            if (v) m_pc = rp;
            else begin
               m_tgt = rp;
               m_kill = 1;
            end
         end else if (v && !s) deliver(d);
         else if (v) begin
            m_buf = d;
            m_have_buf = 1;
         end else if (!s) bubble();
      end
   endfunction

   // one clock: drive inputs, let the edge pass, advance the model
   task automatic cyc(input bit s, input bit r, input logic [31:0] rp);
      bit req, v;
      logic [31:0] d;
      req = rst_n && !m_have_buf;
      v = 0;
      if (req) begin
         if (!mbusy) begin
            mwait = (force_lat >= 0) ? force_lat
                    : int'($urandom_range(0, lat_max));
            force_lat = -1;
            mbusy = 1;
         end
         v = (mwait == 0);
      end
      d = v ? (m_pc ^ key) : $urandom;
      stall_i = s; redirect_i = r; redirect_pc_i = rp;
      imem_valid_i = v; imem_rdata_i = d;
      @(posedge clk); #1;
      if (rst_n) model_step(s, r, rp, v, d);
      if (v) mbusy = 0;
      else if (req) mwait--;
   endtask

   // compare DUT against model every cycle
   always @(negedge clk) begin
      if (started) begin
         chk("req", 32'(imem_req_o), 32'(rst_n && !m_have_buf));
         chk("addr", imem_addr_o, m_pc);
         chk("ifid_pc", if_id_pc_o, m_ipc);
         chk("ifid_pc4", if_id_pc4_o, m_ipc4);
         chk("ifid_inst", if_id_inst_o, m_inst);
         chk("ifid_valid", 32'(if_id_valid_o), 32'(m_ival));
      end
   end

   initial begin
      rst_n = 0; stall_i = 0; redirect_i = 0; redirect_pc_i = 0;
      imem_valid_i = 0; imem_rdata_i = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      started = 1;
      chk("rst_req", 32'(imem_req_o), 32'd0);
      chk("rst_inst", if_id_inst_o, NOP);
      chk("rst_valid", 32'(if_id_valid_o), 32'd0);
      rst_n = 1;

      // zero-wait streaming
      cyc(0, 0, 0);
      chk("zw_pc0", if_id_pc_o, 32'h0);
      chk("zw_inst0", if_id_inst_o, 32'h0);
      cyc(0, 0, 0);
      chk("zw_pc4", if_id_pc_o, 32'h4);
      chk("zw_inst4", if_id_inst_o, 32'h4);
      cyc(0, 0, 0);
      chk("zw_pc8", if_id_pc_o, 32'h8);
      chk("zw_inst8", if_id_inst_o, 32'h8);
      chk("zw_valid", 32'(if_id_valid_o), 32'd1);

      for (int i = 0; i < 20 && m_pc != 32'h10; i++) cyc(0, 0, 0);

      // stall while the 0x10 response lands
      cyc(1, 0, 0);
      chk("hold_req", 32'(imem_req_o), 32'd0);
      chk("hold_ipc", if_id_pc_o, 32'hC);
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      chk("hold_ipc2", if_id_pc_o, 32'hC);
      cyc(0, 0, 0);
      chk("rel_pc", if_id_pc_o, 32'h10);
      chk("rel_pc4", if_id_pc4_o, 32'h14);
      chk("rel_inst", if_id_inst_o, 32'h10);
      chk("rel_addr", imem_addr_o, 32'h14);

      for (int i = 0; i < 40 && m_pc != 32'h40; i++) cyc(0, 0, 0);

      // redirect with a 2-cycle request in flight at 0x40
      force_lat = 2;
      cyc(0, 1, 32'h203);
      chk("kill_valid", 32'(if_id_valid_o), 32'd0);
      cyc(0, 0, 0);
      chk("kill_addr", imem_addr_o, 32'h40);
      cyc(0, 0, 0);
      chk("redir_addr", imem_addr_o, 32'h200);
      chk("redir_valid", 32'(if_id_valid_o), 32'd0);
      cyc(0, 0, 0);
      chk("redir_ipc", if_id_pc_o, 32'h200);
      chk("redir_inst", if_id_inst_o, 32'h200);

      // redirect beats stall
      cyc(1, 1, 32'h100);
      chk("rs_valid", 32'(if_id_valid_o), 32'd0);
      chk("rs_inst", if_id_inst_o, NOP);

      // wraparound
      cyc(0, 1, 32'hFFFF_FFFC);
      cyc(0, 0, 0);
      chk("wrap_pc", if_id_pc_o, 32'hFFFF_FFFC);
      chk("wrap_pc4", if_id_pc4_o, 32'h0);
      chk("wrap_addr", imem_addr_o, 32'h0);

      // reset in the middle of KILL
      force_lat = 3;
      cyc(0, 1, 32'h80);
      #1;
      rst_n = 0;
      model_reset();
      mbusy = 0;
      #1;
      chk("krst_req", 32'(imem_req_o), 32'd0);
      chk("krst_valid", 32'(if_id_valid_o), 32'd0);
      chk("krst_inst", if_id_inst_o, NOP);
      chk("krst_addr", imem_addr_o, RST_PC);
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      #1;
      rst_n = 1;
      #1;
      chk("krel_addr", imem_addr_o, RST_PC);
      chk("krel_req", 32'(imem_req_o), 32'd1);

      // random traffic with variable latency
      lat_max = 2;
      key = 32'h5A5A_0000;
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom % 4) == 0, ($urandom % 10) == 0, $urandom);
      end

      started = 0;
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
